// File: rtl/if_fetch_pkg.sv
// -----------------------------------------------------------------------------
// if_fetch_pkg
// Shared types and constants for the instruction fetch unit.
//   INST_W / ADDR_W  : instruction and address widths
//   CNT_W            : width of the in-flight / buffered credit arithmetic
//   INST_NOP         : instruction shown on inst_o while nothing is valid
//   RESET_ADDR_DEF   : default first fetch address after reset
//   fetch_state_t    : fetch FSM states
//   fetch_entry_t    : one queue entry, {address, instruction}
// -----------------------------------------------------------------------------
package if_fetch_pkg;

    localparam int          INST_W         = 32;
    localparam int          ADDR_W         = 32;
    localparam int          CNT_W          = 3;
    localparam logic [31:0] INST_NOP       = 32'h0000_0013;
    localparam logic [31:0] RESET_ADDR_DEF = 32'h0000_0000;
    localparam logic [31:0] PC_STEP        = 32'd4;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_inst_fifo.sv
// -----------------------------------------------------------------------------
// if_fetch_inst_fifo (inst_fifo)
// DEPTH-entry synchronous queue of {addr, inst} words for the fetch unit.
// The head entry is visible combinationally on o_rdata.
//   clk, rst_n : clock, synchronous active-low reset
//   i_push     : write i_wdata at the tail
//   i_wdata    : entry to write
//   i_pop      : drop the head entry
//   i_clear    : empty the queue; has priority over push and pop
//   o_rdata    : head entry (undefined while empty)
//   o_count    : number of valid entries
//   o_empty    : no valid entries
//   o_full     : DEPTH valid entries
// -----------------------------------------------------------------------------
module if_fetch_inst_fifo
    import if_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  fetch_entry_t     i_wdata,
    input  logic             i_pop,
    input  logic             i_clear,
    output fetch_entry_t     o_rdata,
    output logic [CNT_W-1:0] o_count,
    output logic             o_empty,
    output logic             o_full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_do_push;
    logic             w_do_pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];

    // A push into a full queue is legal when the head leaves in the same cycle.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // NOTE: storage has no reset; r_count alone decides which slots are valid,
    // so the data array can map to plain flops or RAM without a reset network.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

endmodule

// File: rtl/if_fetch.sv
// -----------------------------------------------------------------------------
// if_fetch
// Instruction fetch unit. Owns the PC, issues word reads to the instruction
// ROM over req/gnt/rvalid, buffers returned words in a small queue and
// presents one instruction per cycle, with its address, to if_id. An ex-stage
// jump flushes the queue, marks in-flight reads stale and restarts at the
// target.
//   clk, rst_n      : clock, synchronous active-low reset
//   ex_jump_ena_i   : redirect from ex (jump / taken branch)
//   ex_jump_addr_i  : redirect target, word aligned
//   hold_i          : downstream stall, if_id not accepting
//   rom_req_o       : ROM read request
//   rom_addr_o      : ROM read address
//   rom_gnt_i       : ROM accepted the request this cycle
//   rom_rvalid_i    : ROM read data valid, in request order
//   rom_rdata_i     : ROM read data
//   inst_valid_o    : inst_o / inst_addr_o valid
//   inst_o          : instruction, NOP while invalid
//   inst_addr_o     : instruction address, 0 while invalid
// -----------------------------------------------------------------------------
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = RESET_ADDR_DEF,
    parameter int          DEPTH      = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_jump_ena_i,
    input  logic [ADDR_W-1:0] ex_jump_addr_i,
    input  logic              hold_i,
    output logic              rom_req_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic              rom_gnt_i,
    input  logic              rom_rvalid_i,
    input  logic [INST_W-1:0] rom_rdata_i,
    output logic              inst_valid_o,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_addr_o
);

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;

    logic [ADDR_W-1:0] r_fetch_pc;      // next address to issue
    logic [ADDR_W-1:0] r_resp_pc;       // address of the next useful response
    logic [CNT_W-1:0]  r_outst;         // granted, response not yet seen
    logic [CNT_W-1:0]  r_discard_cnt;   // in-flight responses that are stale

    fetch_entry_t      w_head;
    fetch_entry_t      w_wdata;
    logic [CNT_W-1:0]  w_count;
    logic              w_empty;
    logic              w_full;

    logic [CNT_W-1:0]  w_inflight_sum;
    logic              w_credit;
    logic              w_issue;
    logic              w_drop;
    logic              w_push;
    logic              w_pop;
    logic              w_valid;

    // Every word either in flight or buffered holds a queue slot, so the
    // queue can never overflow no matter how long hold_i stays high.
    assign w_inflight_sum = r_outst + w_count;
    assign w_credit       = (w_inflight_sum < CNT_W'(DEPTH));

    assign w_issue = rom_req_o && rom_gnt_i;
    assign w_drop  = rom_rvalid_i && (r_discard_cnt != '0);

    // A jump in the same cycle as a response drops that response too.
    assign w_push  = rom_rvalid_i && !w_drop && !ex_jump_ena_i && (!w_full || w_pop);
    assign w_wdata = '{addr: r_resp_pc, inst: rom_rdata_i};

    assign w_valid = !w_empty && !ex_jump_ena_i;
    assign w_pop   = w_valid && !hold_i;

    assign rom_addr_o   = r_fetch_pc;
    assign inst_valid_o = w_valid;
    assign inst_o       = w_valid ? w_head.inst : INST_NOP;
    assign inst_addr_o  = w_valid ? w_head.addr : '0;

    if_fetch_inst_fifo #(
        .DEPTH (DEPTH)
    ) u_inst_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .i_clear (ex_jump_ena_i),
        .o_rdata (w_head),
        .o_count (w_count),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        rom_req_o   = 1'b0;

        rom_req_o = (r_state != S_BOOT) && !ex_jump_ena_i && w_credit;

        if (ex_jump_ena_i) begin
            w_state_nxt = S_FLUSH;
        end else begin
            case (r_state)
                S_BOOT:  w_state_nxt = S_RUN;
                S_RUN:   w_state_nxt = S_RUN;
                S_FLUSH: begin
                    if (r_discard_cnt == '0) begin
                        w_state_nxt = S_RUN;
                    end
                end
                default: w_state_nxt = S_BOOT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fetch_pc    <= RESET_ADDR;
            r_resp_pc     <= RESET_ADDR;
            r_outst       <= '0;
            r_discard_cnt <= '0;
        end else if (ex_jump_ena_i) begin
            // rom_req_o is low on a jump cycle, so no grant can land here;
            // everything still in flight becomes stale.
            r_fetch_pc    <= ex_jump_addr_i;
            r_resp_pc     <= ex_jump_addr_i;
            r_outst       <= r_outst - CNT_W'(rom_rvalid_i);
            r_discard_cnt <= r_outst - CNT_W'(rom_rvalid_i);
        end else begin
            if (w_issue) begin
                r_fetch_pc <= r_fetch_pc + PC_STEP;
            end
            r_outst <= r_outst + CNT_W'(w_issue) - CNT_W'(rom_rvalid_i);
            if (w_drop) begin
                r_discard_cnt <= r_discard_cnt - CNT_W'(1);
            end
            if (w_push) begin
                r_resp_pc <= r_resp_pc + PC_STEP;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// -----------------------------------------------------------------------------
// tb_if_fetch
// Directed bench for if_fetch. A ROM model with configurable latency answers
// granted requests; every grant pushes the expected {addr, inst} onto a
// scoreboard, a jump clears it, and every presented instruction is popped and
// compared. Inputs are driven on the falling edge, outputs sampled 1 time
// unit later.
// -----------------------------------------------------------------------------
module tb_if_fetch;
    import if_fetch_pkg::*;

    localparam logic [31:0] RST_A = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_jump_ena_i;
    logic [31:0] ex_jump_addr_i;
    logic        hold_i;
    logic        rom_req_o;
    logic [31:0] rom_addr_o;
    logic        rom_gnt_i;
    logic        rom_rvalid_i;
    logic [31:0] rom_rdata_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;

    always #5 clk = ~clk;

    if_fetch #(
        .RESET_ADDR (RST_A),
        .DEPTH      (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_jump_ena_i  (ex_jump_ena_i),
        .ex_jump_addr_i (ex_jump_addr_i),
        .hold_i         (hold_i),
        .rom_req_o      (rom_req_o),
        .rom_addr_o     (rom_addr_o),
        .rom_gnt_i      (rom_gnt_i),
        .rom_rvalid_i   (rom_rvalid_i),
        .rom_rdata_i    (rom_rdata_i),
        .inst_valid_o   (inst_valid_o),
        .inst_o         (inst_o),
        .inst_addr_o    (inst_addr_o)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } rom_txn_t;

    rom_txn_t     rom_q[$];
    fetch_entry_t exp_q[$];

    int          total       = 0;
    int          bad         = 0;
    int          cyc         = 0;
    int          lat         = 1;
    int          last_rv_cyc = -10;
    bit          jump_now    = 0;
    bit          hold_now    = 0;
    bit          rst_now     = 1;
    bit          watch_first = 1;
    logic [31:0] jump_tgt    = '0;
    logic [31:0] exp_fetch   = RST_A;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, let the ROM answer, then score outputs.
    task automatic cycle();
        rom_txn_t r;
        bit       rv_kept;
        @(negedge clk);
        cyc++;
        rv_kept        = 1'b0;
        rst_n          = !rst_now;
        ex_jump_ena_i  = jump_now;
        ex_jump_addr_i = jump_tgt;
        hold_i         = hold_now;
        rom_rvalid_i   = 1'b0;
        rom_rdata_i    = '0;
        if (rst_now) begin
            rom_q.delete();
            exp_q.delete();
            exp_fetch   = RST_A;
            watch_first = 1'b1;
        end else if (rom_q.size() > 0 && rom_q[0].due <= cyc) begin
            r            = rom_q.pop_front();
            rom_rvalid_i = 1'b1;
            rom_rdata_i  = rom_word(r.addr);
            rv_kept      = !r.stale && !jump_now;
        end
        #1;
        if (rst_now) return;
        if (jump_now) begin
            chk("jump_cycle_valid", inst_valid_o, 0);
            chk("jump_cycle_req", rom_req_o, 0);
            exp_q.delete();
            foreach (rom_q[i]) rom_q[i].stale = 1'b1;
            exp_fetch   = jump_tgt;
            watch_first = 1'b1;
        end else begin
            if (rom_req_o && rom_gnt_i) begin
                chk("rom_addr", rom_addr_o, exp_fetch);
                rom_q.push_back('{addr: rom_addr_o, due: cyc + lat, stale: 1'b0});
                exp_q.push_back('{addr: exp_fetch, inst: rom_word(exp_fetch)});
                exp_fetch += 32'd4;
            end
            if (inst_valid_o) begin
                if (watch_first) begin
                    chk("first_latency", cyc, last_rv_cyc + 1);
                    watch_first = 1'b0;
                end
                if (exp_q.size() == 0) begin
                    chk("unexpected_inst", inst_valid_o, 0);
                end else begin
                    chk("inst_addr", inst_addr_o, exp_q[0].addr);
                    chk("inst_data", inst_o, exp_q[0].inst);
                    if (!hold_now) void'(exp_q.pop_front());
                end
            end else begin
                chk("idle_inst", inst_o, INST_NOP);
                chk("idle_addr", inst_addr_o, 0);
            end
        end
        if (rv_kept) last_rv_cyc = cyc;
    endtask

    task automatic do_reset();
        rst_now = 1'b1;
        cycle();
        rst_now = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req"}, rom_req_o, 0);
        chk({tag, "_rom_addr"}, rom_addr_o, RST_A);
        chk({tag, "_valid"}, inst_valid_o, 0);
        chk({tag, "_inst"}, inst_o, INST_NOP);
        chk({tag, "_addr"}, inst_addr_o, 0);
    endtask

    task automatic run_until_valid(input string tag, input logic [31:0] exp_addr);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            cycle();
            if (inst_valid_o && !jump_now) begin
                seen = 1'b1;
                chk(tag, inst_addr_o, exp_addr);
            end
        end
        if (!seen) chk({tag, "_timeout"}, inst_valid_o, 1);
    endtask

    task automatic jump_to(input logic [31:0] tgt);
        jump_now = 1'b1;
        jump_tgt = tgt;
        cycle();
        jump_now = 1'b0;
    endtask

    initial begin
        rst_n          = 1'b0;
        ex_jump_ena_i  = 1'b0;
        ex_jump_addr_i = '0;
        hold_i         = 1'b0;
        rom_gnt_i      = 1'b1;
        rom_rvalid_i   = 1'b0;
        rom_rdata_i    = '0;

        // Reset, then straight-line fetch with a 1-cycle ROM.
        lat = 1;
        do_reset();
        do_reset();
        cycle();
        check_reset_outputs("rst");
        cycle();
        chk("first_req", rom_req_o, 1);
        chk("first_req_addr", rom_addr_o, RST_A);
        run_until_valid("t1_addr0", 32'h0);
        run_until_valid("t1_addr4", 32'h4);
        run_until_valid("t1_addr8", 32'h8);

        // Hold for 5 cycles: queue fills, requests stop, head stays at 0x0.
        do_reset();
        hold_now = 1'b1;
        for (int i = 0; i < 5; i++) cycle();
        chk("t2_full_req_low", rom_req_o, 0);
        chk("t2_held_valid", inst_valid_o, 1);
        chk("t2_held_addr", inst_addr_o, 32'h0);
        hold_now = 1'b0;
        cycle();
        chk("t2_release_addr", inst_addr_o, 32'h0);
        cycle();
        chk("t2_no_gap_valid", inst_valid_o, 1);
        chk("t2_no_gap_addr", inst_addr_o, 32'h4);

        // Two reads in flight on a 3-cycle ROM, then jump to 0x100.
        lat = 3;
        do_reset();
        for (int i = 0; i < 20 && rom_q.size() < 2; i++) cycle();
        chk("t3_two_in_flight", rom_q.size(), 2);
        jump_to(32'h100);
        run_until_valid("t3_target", 32'h100);
        run_until_valid("t3_target_next", 32'h104);

        // Jump in the same cycle as the response for 0x8.
        lat = 1;
        do_reset();
        for (int i = 0; i < 30; i++) begin
            if (rom_q.size() > 0 && rom_q[0].addr == 32'h8 && rom_q[0].due == cyc + 1) break;
            cycle();
        end
        chk("t4_resp8_pending", rom_q[0].addr, 32'h8);
        jump_to(32'h200);
        run_until_valid("t4_target", 32'h200);

        // Reset mid-stream with fetch_pc at 0x40.
        do_reset();
        for (int i = 0; i < 100 && exp_fetch != 32'h40; i++) cycle();
        rst_now = 1'b1;
        cycle();
        chk("t5_pc_before_reset", rom_addr_o, 32'h40);
        rst_now = 1'b0;
        cycle();
        check_reset_outputs("t5_rst");
        cycle();
        chk("t5_resume_req", rom_req_o, 1);
        run_until_valid("t5_resume", RST_A);

        // Jump to the top word: fetch wraps to 0x0.
        jump_to(32'hFFFF_FFFC);
        run_until_valid("t6_wrap_hi", 32'hFFFF_FFFC);
        run_until_valid("t6_wrap_lo", 32'h0000_0000);

        for (int i = 0; i < 5; i++) cycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
